// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: PLL reset pulse, lock qualification and ordered
// release of domain resets, with lock supervision and restart.
module clk_rst_sequencer #(
    parameter int N_DOM        = 4,
    parameter int LOCK_STABLE  = 1024,
    parameter int STEP_GAP     = 16,
    parameter int PLL_RST_LEN  = 8,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic             ext_clk,
    input  logic             ext_rst,
    input  logic             pll_locked,
    input  logic             sw_restart,
    output logic             pll_areset,
    output logic [N_DOM-1:0] dom_rst,
    output logic             seq_done,
    output logic             lock_fault,
    output logic [7:0]       relock_cnt
);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    localparam logic [31:0] RST_LAST = 32'(PLL_RST_LEN - 1);
    localparam logic [31:0] TO_LAST  = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] STB_LAST = 32'(LOCK_STABLE - 1);
    localparam logic [31:0] GAP_LAST = 32'(STEP_GAP - 1);

    state_t           state, state_nxt;
    logic [31:0]      cnt, cnt_nxt;
    logic             areset_nxt;
    logic [N_DOM-1:0] dom_nxt;
    logic [N_DOM-1:0] dom_shift;
    logic             done_nxt;
    logic             fault_nxt;
    logic [7:0]       relock_nxt;
    logic [7:0]       relock_inc;
    logic             go_pll;
    logic             sync1;
    logic             locked_s;

    // Releasing one more domain is a left shift: bit 0 clears first.
    assign dom_shift  = dom_rst << 1;
    assign relock_inc = (relock_cnt == 8'hFF) ? relock_cnt
                                              : relock_cnt + 8'd1;

    // Lock is meaningless while the PLL is held in reset, so the
    // synchronizer is flushed whenever pll_areset is high next cycle.
    always_ff @(posedge ext_clk) begin
        if (ext_rst || areset_nxt) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge ext_clk) begin
        if (ext_rst) begin
            state      <= PLL_RST;
            cnt        <= '0;
            pll_areset <= 1'b1;
            dom_rst    <= '1;
            seq_done   <= 1'b0;
            lock_fault <= 1'b0;
            relock_cnt <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pll_areset <= areset_nxt;
            dom_rst    <= dom_nxt;
            seq_done   <= done_nxt;
            lock_fault <= fault_nxt;
            relock_cnt <= relock_nxt;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 32'd1;
        areset_nxt = pll_areset;
        dom_nxt    = dom_rst;
        done_nxt   = seq_done;
        fault_nxt  = lock_fault;
        relock_nxt = relock_cnt;
        go_pll     = 1'b0;
        unique case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt  = WAIT_LOCK;
                    cnt_nxt    = '0;
                    areset_nxt = 1'b0;
                end
            end
            WAIT_LOCK: begin
                if (sw_restart) begin
                    go_pll = 1'b1;
                end else if (locked_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    go_pll     = 1'b1;
                    fault_nxt  = 1'b1;
                    relock_nxt = relock_inc;
                end
            end
            STABLE: begin
                if (sw_restart) begin
                    go_pll = 1'b1;
                end else if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STB_LAST) begin
                    dom_nxt = dom_shift;
                    cnt_nxt = '0;
                    if (dom_shift == '0) begin
                        state_nxt = RUN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    go_pll     = 1'b1;
                    relock_nxt = relock_inc;
                end else if (sw_restart) begin
                    go_pll = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    dom_nxt = dom_shift;
                    cnt_nxt = '0;
                    if (dom_shift == '0) begin
                        state_nxt = RUN;
                        done_nxt  = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_nxt = cnt;
                if (!locked_s) begin
                    go_pll     = 1'b1;
                    relock_nxt = relock_inc;
                end else if (sw_restart) begin
                    go_pll = 1'b1;
                end
            end
            default: go_pll = 1'b1;
        endcase
        if (go_pll) begin
            state_nxt  = PLL_RST;
            cnt_nxt    = '0;
            areset_nxt = 1'b1;
            dom_nxt    = '1;
            done_nxt   = 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb_clk_rst_sequencer: vector table, directed corner sequences and
// random stimulus against a timestamp-based reference model.
module tb_clk_rst_sequencer;

    localparam int N  = 3;
    localparam int LS = 8;
    localparam int G  = 4;
    localparam int L  = 3;
    localparam int TO = 50;

    localparam int M_PLL  = 0;
    localparam int M_WAIT = 1;
    localparam int M_QUAL = 2;
    localparam int M_REL  = 3;
    localparam int M_RUN  = 4;

    logic         clk;
    logic         ext_rst;
    logic         pll_locked;
    logic         sw_restart;
    logic         pll_areset;
    logic [N-1:0] dom_rst;
    logic         seq_done;
    logic         lock_fault;
    logic [7:0]   relock_cnt;

    int n_chk;
    int n_fail;

    int   n;
    int   t_ent;
    int   ph;
    logic ms1;
    logic ms2;
    logic m_fault;
    int   m_cnt;

    typedef struct {
        logic       rst;
        logic       lk;
        logic       sw;
        int         ncyc;
        logic       are;
        logic [2:0] dom;
        logic       done;
        logic       fault;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [10];

    clk_rst_sequencer #(
        .N_DOM       (N),
        .LOCK_STABLE (LS),
        .STEP_GAP    (G),
        .PLL_RST_LEN (L),
        .LOCK_TIMEOUT(TO)
    ) dut (
        .ext_clk   (clk),
        .ext_rst   (ext_rst),
        .pll_locked(pll_locked),
        .sw_restart(sw_restart),
        .pll_areset(pll_areset),
        .dom_rst   (dom_rst),
        .seq_done  (seq_done),
        .lock_fault(lock_fault),
        .relock_cnt(relock_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, n);
        end
    endtask

    task automatic m_enter(input int p);
        ph    = p;
        t_ent = n;
    endtask

    task automatic m_bump();
        if (m_cnt < 255) m_cnt++;
    endtask

    // Reference: phase plus the edge it was entered on; all timing is
    // derived from elapsed edges rather than from running counters.
    task automatic model_edge();
        logic ls;
        logic flush;
        int   k;
        n++;
        ls = ms2;
        k  = n - t_ent;
        if (ext_rst) begin
            m_enter(M_PLL);
            m_fault = 1'b0;
            m_cnt   = 0;
        end else begin
            case (ph)
                M_PLL: if (k == L) m_enter(M_WAIT);
                M_WAIT: begin
                    if (sw_restart) m_enter(M_PLL);
                    else if (ls) m_enter(M_QUAL);
                    else if (k == TO) begin
                        m_enter(M_PLL);
                        m_fault = 1'b1;
                        m_bump();
                    end
                end
                M_QUAL: begin
                    if (sw_restart) m_enter(M_PLL);
                    else if (!ls) m_enter(M_WAIT);
                    else if (k == LS) m_enter(N == 1 ? M_RUN : M_REL);
                end
                default: begin
                    if (!ls) begin
                        m_enter(M_PLL);
                        m_bump();
                    end else if (sw_restart) begin
                        m_enter(M_PLL);
                    end else if (ph == M_REL && k >= (N - 1) * G) begin
                        ph = M_RUN;
                    end
                end
            endcase
        end
        flush = ext_rst || (ph == M_PLL);
        ms2 = flush ? 1'b0 : ms1;
        ms1 = flush ? 1'b0 : pll_locked;
    endtask

    function automatic logic [2:0] m_dom();
        logic [2:0] ones;
        ones = '1;
        if (ph == M_RUN) return 3'b000;
        if (ph == M_REL) return ones << (1 + (n - t_ent) / G);
        return ones;
    endfunction

    task automatic check_model();
        chk("model_pll_areset", 32'(pll_areset), 32'(ph == M_PLL));
        chk("model_dom_rst", 32'(dom_rst), 32'(m_dom()));
        chk("model_seq_done", 32'(seq_done), 32'(ph == M_RUN));
        chk("model_lock_fault", 32'(lock_fault), 32'(m_fault));
        chk("model_relock_cnt", 32'(relock_cnt), 32'(m_cnt));
    endtask

    task automatic step(input logic r, input logic lk, input logic sw);
        @(negedge clk);
        ext_rst    = r;
        pll_locked = lk;
        sw_restart = sw;
        @(posedge clk);
        #1;
        model_edge();
        check_model();
    endtask

    task automatic wait_dom(input logic [2:0] tgt, input int budget,
                            input string nm);
        for (int i = 0; i < budget; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (dom_rst == tgt) break;
        end
        chk(nm, 32'(dom_rst), 32'(tgt));
    endtask

    task automatic wait_done(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (seq_done) break;
        end
        chk(nm, 32'(seq_done), 32'd1);
    endtask

    initial begin
        int   k;
        logic lk;
        logic r;
        logic sw;
        n_chk      = 0;
        n_fail     = 0;
        n          = 0;
        t_ent      = 0;
        ph         = M_PLL;
        ms1        = 1'b0;
        ms2        = 1'b0;
        m_fault    = 1'b0;
        m_cnt      = 0;
        ext_rst    = 1'b1;
        pll_locked = 1'b1;
        sw_restart = 1'b0;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 2, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 2, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 9, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 3'b110, 1'b0, 1'b0, 8'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 3'b110, 1'b0, 1'b0, 8'd0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 3'b100, 1'b0, 1'b0, 8'd0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 3'b100, 1'b0, 1'b0, 8'd0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 3'b000, 1'b1, 1'b0, 8'd0};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 5, 1'b0, 3'b000, 1'b1, 1'b0, 8'd0};

        // Power-up sequence from the vector table.
        for (int i = 0; i < 10; i++) begin
            repeat (tbl[i].ncyc) step(tbl[i].rst, tbl[i].lk, tbl[i].sw);
            chk($sformatf("pwr%0d_areset", i), 32'(pll_areset),
                32'(tbl[i].are));
            chk($sformatf("pwr%0d_dom", i), 32'(dom_rst), 32'(tbl[i].dom));
            chk($sformatf("pwr%0d_done", i), 32'(seq_done),
                32'(tbl[i].done));
            chk($sformatf("pwr%0d_fault", i), 32'(lock_fault),
                32'(tbl[i].fault));
            chk($sformatf("pwr%0d_cnt", i), 32'(relock_cnt),
                32'(tbl[i].cnt));
        end

        // Lock loss in RUN: seen two sync cycles later.
        step(1'b0, 1'b0, 1'b0);
        chk("loss_dom_a", 32'(dom_rst), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("loss_dom_b", 32'(dom_rst), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("loss_dom", 32'(dom_rst), 32'h7);
        chk("loss_done", 32'(seq_done), 32'd0);
        chk("loss_cnt", 32'(relock_cnt), 32'd1);
        wait_done(100, "loss_rerun_done");

        // sw_restart in RUN and in RELEASE: count unchanged.
        step(1'b0, 1'b1, 1'b1);
        chk("swrun_dom", 32'(dom_rst), 32'h7);
        wait_dom(3'b110, 100, "swrel_reach");
        step(1'b0, 1'b1, 1'b1);
        chk("swrel_dom", 32'(dom_rst), 32'h7);
        chk("swrel_areset", 32'(pll_areset), 32'd1);
        chk("swrel_cnt", 32'(relock_cnt), 32'd1);

        // sw_restart on the same edge as lock loss counts once.
        wait_dom(3'b110, 100, "both_reach");
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("both_dom", 32'(dom_rst), 32'h7);
        chk("both_cnt", 32'(relock_cnt), 32'd2);

        // Lock glitch while qualifying.
        step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (dom_rst[0] == 1'b0) begin
                k = i;
                break;
            end
        end
        chk("glitch_delay", 32'(k), 32'd11);
        chk("glitch_cnt", 32'(relock_cnt), 32'd0);

        // Lock never asserted: repeated timeouts.
        step(1'b1, 1'b0, 1'b0);
        repeat (52) step(1'b0, 1'b0, 1'b0);
        chk("to_pre_fault", 32'(lock_fault), 32'd0);
        chk("to_pre_areset", 32'(pll_areset), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("to1_fault", 32'(lock_fault), 32'd1);
        chk("to1_cnt", 32'(relock_cnt), 32'd1);
        chk("to1_areset", 32'(pll_areset), 32'd1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        chk("to1_pulse_hi", 32'(pll_areset), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("to1_pulse_lo", 32'(pll_areset), 32'd0);
        repeat (49) step(1'b0, 1'b0, 1'b0);
        chk("to2_pre_cnt", 32'(relock_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("to2_cnt", 32'(relock_cnt), 32'd2);
        wait_done(100, "to_lock_done");
        chk("to_sticky", 32'(lock_fault), 32'd1);

        // ext_rst mid-RELEASE.
        step(1'b0, 1'b1, 1'b1);
        wait_dom(3'b110, 100, "rst_reach");
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_areset", 32'(pll_areset), 32'd1);
        chk("rst_dom", 32'(dom_rst), 32'h7);
        chk("rst_done", 32'(seq_done), 32'd0);
        chk("rst_fault", 32'(lock_fault), 32'd0);
        chk("rst_cnt", 32'(relock_cnt), 32'd0);

        // Saturation after 260 lock losses.
        for (int i = 0; i < 260; i++) begin
            wait_dom(3'b110, 60, "sat_reach");
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            if (i == 254) chk("sat_255", 32'(relock_cnt), 32'd255);
        end
        chk("sat_hold", 32'(relock_cnt), 32'd255);

        // Random stimulus against the model.
        step(1'b1, 1'b1, 1'b0);
        lk = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (lk) lk = ($urandom_range(0, 59) != 0);
            else lk = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 999) == 0);
            sw = ($urandom_range(0, 149) == 0);
            step(r, lk, sw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
